// File: rtl/output_link_tx_if.sv
// Shared flit format plus the crossbar-side / link-side signal bundle of output_link_tx.
// The tx block takes the slave modport; the crossbar/link model drives the master side.
package noc_params;
    localparam int VC_NUM  = 4;
    localparam int VC_SIZE = $clog2(VC_NUM);

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_SIZE-1:0]   vc_id;
        logic [15:0]          data;
    } flit_t;
endpackage

interface output_link_tx_if
    import noc_params::flit_t;
#(
    parameter int VC_NUM = noc_params::VC_NUM
);
    flit_t              data_i;
    logic               valid_flit_i;
    logic [VC_NUM-1:0]  on_off_i;
    flit_t              data_o;
    logic               valid_flit_o;
    logic [VC_NUM-1:0]  is_full_o;
    logic [VC_NUM-1:0]  is_empty_o;
    logic               overflow_o;

    modport slave (
        input  data_i, valid_flit_i, on_off_i,
        output data_o, valid_flit_o, is_full_o, is_empty_o, overflow_o
    );

    modport master (
        output data_i, valid_flit_i, on_off_i,
        input  data_o, valid_flit_o, is_full_o, is_empty_o, overflow_o
    );
endinterface

// File: rtl/output_link_tx.sv
// Inter-router link transmitter: per-VC staging FIFOs, on/off-gated VC arbitration, registered link output.
// Define OUTPUT_LINK_RR_ARB_EN for round-robin arbitration; default build is fixed lowest-index priority.

module output_link_fifo
    import noc_params::flit_t;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  flit_t wr_data,
    input  logic  push,
    input  logic  pop,
    output flit_t head,
    output logic  full,
    output logic  empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    flit_t              mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    // storage carries no reset; validity is tracked entirely by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

module output_link_tx
    import noc_params::flit_t;
    import noc_params::VC_SIZE;
#(
    parameter int VC_NUM      = noc_params::VC_NUM,
    parameter int STAGE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output_link_tx_if.slave link
);
    localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    flit_t [VC_NUM-1:0] head;
    logic  [VC_NUM-1:0] full;
    logic  [VC_NUM-1:0] empty;
    logic  [VC_NUM-1:0] hit;
    logic  [VC_NUM-1:0] push;
    logic  [VC_NUM-1:0] pop;
    logic  [VC_NUM-1:0] drop;
    logic  [VC_NUM-1:0] elig;
    logic  [VC_W-1:0]   gnt_idx;
    logic               gnt_vld;

    flit_t              data_q;
    logic               valid_q;
    logic               overflow_q;

    // A full FIFO still accepts when it is popped in the same cycle.
    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        assign hit[v]  = link.valid_flit_i && (link.data_i.vc_id == VC_SIZE'(v));
        assign push[v] = hit[v] && (!full[v] || pop[v]);
        assign drop[v] = hit[v] && full[v] && !pop[v];

        output_link_fifo #(.DEPTH(STAGE_DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_data (link.data_i),
            .push    (push[v]),
            .pop     (pop[v]),
            .head    (head[v]),
            .full    (full[v]),
            .empty   (empty[v])
        );
    end

    assign elig = ~empty & link.on_off_i;

`ifdef OUTPUT_LINK_RR_ARB_EN
    // rr_ptr names the VC with highest priority this cycle (one past the last grant)
    logic [VC_W-1:0] rr_ptr;
    logic [VC_W:0]   sum;
    logic [VC_W-1:0] cand;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < VC_NUM; k++) begin
            sum = {1'b0, rr_ptr} + (VC_W+1)'(k);
            if (sum >= (VC_W+1)'(VC_NUM)) sum = sum - (VC_W+1)'(VC_NUM);
            cand = sum[VC_W-1:0];
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (gnt_vld) begin
            rr_ptr <= (gnt_idx == VC_W'(VC_NUM-1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`else
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < VC_NUM; k++) begin
            if (!gnt_vld && elig[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = VC_W'(k);
            end
        end
    end
`endif

    always_comb begin
        pop = '0;
        if (gnt_vld) pop[gnt_idx] = 1'b1;
    end

    // data_q holds its last value on idle cycles; only valid_q drops
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= gnt_vld;
            if (gnt_vld) data_q <= head[gnt_idx];
            if (|drop)   overflow_q <= 1'b1;
        end
    end

    assign link.data_o       = data_q;
    assign link.valid_flit_o = valid_q;
    assign link.overflow_o   = overflow_q;
    assign link.is_full_o    = full;
    assign link.is_empty_o   = empty;
endmodule

// File: tb/tb_output_link_tx.sv
// Directed self-checking bench for output_link_tx (VC_NUM=4, STAGE_DEPTH=4).
module tb_output_link_tx;
    import noc_params::*;

    localparam int VCN   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    output_link_tx_if #(.VC_NUM(VCN)) lnk();

    output_link_tx #(.VC_NUM(VCN), .STAGE_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (lnk)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic flit_t mk(int vc, int d);
        flit_t f;
        f.flit_label = HEADTAIL;
        f.vc_id      = VC_SIZE'(vc);
        f.data       = 16'(d);
        return f;
    endfunction

    task automatic push_flit(flit_t f);
        lnk.data_i       = f;
        lnk.valid_flit_i = 1'b1;
        tick();
        lnk.valid_flit_i = 1'b0;
    endtask

    task automatic do_reset();
        rst              = 1'b0;
        lnk.valid_flit_i = 1'b0;
        lnk.on_off_i     = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst              = 1'b0;
        lnk.on_off_i     = '1;
        lnk.data_i       = mk(1, 16'h1234);
        lnk.valid_flit_i = 1'b1;
        tick();
        tick();
        checks++; if (lnk.valid_flit_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", lnk.valid_flit_o); end
        checks++; if (lnk.data_o !== flit_t'('0)) begin errors++; $display("FAIL reset_data got %h exp 0", lnk.data_o); end
        checks++; if (lnk.is_empty_o !== 4'b1111) begin errors++; $display("FAIL reset_empty got %b exp 1111", lnk.is_empty_o); end
        checks++; if (lnk.is_full_o !== 4'b0000) begin errors++; $display("FAIL reset_full got %b exp 0000", lnk.is_full_o); end
        checks++; if (lnk.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", lnk.overflow_o); end
        lnk.valid_flit_i = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_single();
        flit_t f;
        f = mk(1, 16'hA5A5);
        lnk.on_off_i = '1;
        push_flit(f);
        checks++; if (lnk.valid_flit_o !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", lnk.valid_flit_o); end
        checks++; if (lnk.is_empty_o !== 4'b1101) begin errors++; $display("FAIL single_empty_staged got %b exp 1101", lnk.is_empty_o); end
        tick();
        checks++; if (lnk.valid_flit_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", lnk.valid_flit_o); end
        checks++; if (lnk.data_o !== f) begin errors++; $display("FAIL single_data got %h exp %h", lnk.data_o, f); end
        checks++; if (lnk.data_o.vc_id !== 2'd1) begin errors++; $display("FAIL single_vc got %0d exp 1", lnk.data_o.vc_id); end
        checks++; if (lnk.is_empty_o !== 4'b1111) begin errors++; $display("FAIL single_empty_after got %b exp 1111", lnk.is_empty_o); end
        tick();
        checks++; if (lnk.valid_flit_o !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", lnk.valid_flit_o); end
        checks++; if (lnk.data_o !== f) begin errors++; $display("FAIL single_hold got %h exp %h", lnk.data_o, f); end
    endtask

    task automatic test_overflow();
        do_reset();
        lnk.on_off_i = 4'b1110;
        for (int i = 0; i < 4; i++) push_flit(mk(0, 16'h10 + i));
        checks++; if (lnk.is_full_o !== 4'b0001) begin errors++; $display("FAIL ovf_full got %b exp 0001", lnk.is_full_o); end
        checks++; if (lnk.valid_flit_o !== 1'b0) begin errors++; $display("FAIL ovf_off_valid got %b exp 0", lnk.valid_flit_o); end
        checks++; if (lnk.overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", lnk.overflow_o); end
        push_flit(mk(0, 16'h99));
        checks++; if (lnk.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", lnk.overflow_o); end
        lnk.on_off_i = '1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (lnk.valid_flit_o !== 1'b1 || lnk.data_o !== mk(0, 16'h10 + i)) begin
                errors++; $display("FAIL ovf_drain%0d got v=%b %h exp v=1 %h", i, lnk.valid_flit_o, lnk.data_o, mk(0, 16'h10 + i));
            end
        end
        tick();
        checks++; if (lnk.valid_flit_o !== 1'b0) begin errors++; $display("FAIL ovf_discarded got v=%b %h exp v=0", lnk.valid_flit_o, lnk.data_o); end
        checks++; if (lnk.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", lnk.overflow_o); end
    endtask

    task automatic test_push_pop_full();
        int exp_d[4];
        exp_d = '{16'h21, 16'h22, 16'h23, 16'h55};
        do_reset();
        lnk.on_off_i = 4'b1110;
        for (int i = 0; i < 4; i++) push_flit(mk(0, 16'h20 + i));
        lnk.on_off_i = '1;
        push_flit(mk(0, 16'h55));
        lnk.on_off_i = 4'b1110;
        checks++; if (lnk.overflow_o !== 1'b0) begin errors++; $display("FAIL pp_overflow got %b exp 0", lnk.overflow_o); end
        checks++; if (lnk.is_full_o !== 4'b0001) begin errors++; $display("FAIL pp_full got %b exp 0001", lnk.is_full_o); end
        checks++; if (lnk.data_o !== mk(0, 16'h20)) begin errors++; $display("FAIL pp_first got %h exp %h", lnk.data_o, mk(0, 16'h20)); end
        lnk.on_off_i = '1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (lnk.valid_flit_o !== 1'b1 || lnk.data_o !== mk(0, exp_d[i])) begin
                errors++; $display("FAIL pp_drain%0d got v=%b %h exp v=1 %h", i, lnk.valid_flit_o, lnk.data_o, mk(0, exp_d[i]));
            end
        end
    endtask

    task automatic test_arbitration();
        flit_t exp_f[6];
`ifdef OUTPUT_LINK_RR_ARB_EN
        for (int i = 0; i < 3; i++) begin
            exp_f[2*i]   = mk(0, 16'h100 + i);
            exp_f[2*i+1] = mk(1, 16'h200 + i);
        end
`else
        for (int i = 0; i < 3; i++) begin
            exp_f[i]   = mk(0, 16'h100 + i);
            exp_f[i+3] = mk(1, 16'h200 + i);
        end
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_flit(mk(0, 16'h100 + i));
            push_flit(mk(1, 16'h200 + i));
        end
        lnk.on_off_i = '1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (lnk.valid_flit_o !== 1'b1 || lnk.data_o !== exp_f[i]) begin
                errors++; $display("FAIL arb_seq%0d got v=%b %h exp v=1 %h", i, lnk.valid_flit_o, lnk.data_o, exp_f[i]);
            end
        end
        tick();
        checks++; if (lnk.valid_flit_o !== 1'b0) begin errors++; $display("FAIL arb_end got %b exp 0", lnk.valid_flit_o); end
    endtask

    task automatic test_on_off_toggle();
        do_reset();
        for (int i = 0; i < 4; i++) push_flit(mk(1, 16'h30 + i));
        lnk.on_off_i = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (lnk.valid_flit_o !== 1'b1 || lnk.data_o !== mk(1, 16'h30 + i)) begin
                errors++; $display("FAIL tog_pre%0d got v=%b %h exp v=1 %h", i, lnk.valid_flit_o, lnk.data_o, mk(1, 16'h30 + i));
            end
        end
        lnk.on_off_i = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (lnk.valid_flit_o !== 1'b0) begin errors++; $display("FAIL tog_off%0d got v=%b exp v=0", i, lnk.valid_flit_o); end
        end
        checks++; if (lnk.is_empty_o[1] !== 1'b0) begin errors++; $display("FAIL tog_kept got empty=%b exp 0", lnk.is_empty_o[1]); end
        lnk.on_off_i = 4'b0010;
        for (int i = 2; i < 4; i++) begin
            tick();
            checks++;
            if (lnk.valid_flit_o !== 1'b1 || lnk.data_o !== mk(1, 16'h30 + i)) begin
                errors++; $display("FAIL tog_post%0d got v=%b %h exp v=1 %h", i, lnk.valid_flit_o, lnk.data_o, mk(1, 16'h30 + i));
            end
        end
        tick();
        checks++; if (lnk.valid_flit_o !== 1'b0) begin errors++; $display("FAIL tog_end got %b exp 0", lnk.valid_flit_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) push_flit(mk(2, 16'h40 + i));
        push_flit(mk(0, 16'h50));
        push_flit(mk(0, 16'h51));
        checks++; if (lnk.overflow_o !== 1'b1) begin errors++; $display("FAIL rmid_ovf_pre got %b exp 1", lnk.overflow_o); end
        lnk.on_off_i = '1;
        tick();
        checks++; if (lnk.valid_flit_o !== 1'b1 || lnk.data_o !== mk(0, 16'h50)) begin errors++; $display("FAIL rmid_pre got v=%b %h exp v=1 %h", lnk.valid_flit_o, lnk.data_o, mk(0, 16'h50)); end
        rst              = 1'b0;
        lnk.data_i       = mk(3, 16'h77);
        lnk.valid_flit_i = 1'b1;
        tick();
        lnk.valid_flit_i = 1'b0;
        checks++; if (lnk.valid_flit_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", lnk.valid_flit_o); end
        checks++; if (lnk.is_empty_o !== 4'b1111) begin errors++; $display("FAIL rmid_empty got %b exp 1111", lnk.is_empty_o); end
        checks++; if (lnk.is_full_o !== 4'b0000) begin errors++; $display("FAIL rmid_full got %b exp 0000", lnk.is_full_o); end
        checks++; if (lnk.overflow_o !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b exp 0", lnk.overflow_o); end
        checks++; if (lnk.data_o !== flit_t'('0)) begin errors++; $display("FAIL rmid_data got %h exp 0", lnk.data_o); end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (lnk.valid_flit_o !== 1'b0) begin errors++; $display("FAIL rmid_post%0d got v=%b %h exp v=0", i, lnk.valid_flit_o, lnk.data_o); end
        end
    endtask

    initial begin
        lnk.data_i       = '0;
        lnk.valid_flit_i = 1'b0;
        lnk.on_off_i     = '0;
        test_reset();
        test_single();
        test_overflow();
        test_push_pop_full();
        test_arbitration();
        test_on_off_toggle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
